memory_arbiter: RTL

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter in front of a single-port word memory.
// Port 0 is instruction fetch, port 1 is data. Each transaction takes
// IDLE (grant) -> ACCESS (memory driven) -> RESP (one-cycle ack).
// Addresses at or beyond SIZE never reach the memory as writes and
// complete with err set and rdata cleared.
module memory_arbiter #(
    parameter int SIZE = 80
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] mem_address,
    output logic        mem_mode,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic        r_lastGrant;
    logic        r_grant;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_anyReq;
    logic        w_winner;
    logic        w_winWe;
    logic [31:0] w_winAddr;
    logic [31:0] w_winWdata;
    logic        w_inRange;

    // Unsigned full-width bound check on the latched address.
    assign w_inRange = (r_addr < 32'(SIZE));
    assign w_anyReq  = req0 | req1;

    // Winner selection: lone requester wins, contention goes to the port not served last.
    always_comb begin
        w_winner   = 1'b0;
        w_winWe    = we0;
        w_winAddr  = addr0;
        w_winWdata = wdata0;
        if (req0 && req1) begin
            w_winner = ~r_lastGrant;
        end else if (req1) begin
            w_winner = 1'b1;
        end
        if (w_winner) begin
            w_winWe    = we1;
            w_winAddr  = addr1;
            w_winWdata = wdata1;
        end
    end

    // State register; reset drops straight back to IDLE, which also kills any write in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and memory/ack outputs; memory is only driven during ACCESS.
    always_comb begin
        w_nextState = r_state;
        ack0        = 1'b0;
        ack1        = 1'b0;
        mem_mode    = 1'b0;
        mem_address = 32'd0;
        mem_data_in = 32'd0;
        case (r_state)
            IDLE: begin
                if (w_anyReq) begin
                    w_nextState = ACCESS;
                end
            end
            ACCESS: begin
                mem_address = r_addr;
                mem_data_in = r_wdata;
                mem_mode    = r_we & w_inRange;
                w_nextState = RESP;
            end
            RESP: begin
                ack0        = ~r_grant;
                ack1        = r_grant;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Transaction capture at grant, and result capture at the end of ACCESS.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lastGrant <= 1'b1;
            r_grant     <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            if (r_state == IDLE && w_anyReq) begin
                r_grant     <= w_winner;
                r_lastGrant <= w_winner;
                r_we        <= w_winWe;
                r_addr      <= w_winAddr;
                r_wdata     <= w_winWdata;
            end
            if (r_state == ACCESS) begin
                r_rdata <= (!r_we && w_inRange) ? mem_data_out : 32'd0;
                r_err   <= ~w_inRange;
            end
        end
    end

    assign rdata = r_rdata;
    assign err   = r_err;

endmodule
